vtiming_gen: RTL and testbench
==============================

# vtiming_gen

Parametrised vertical timing generator for the VGA scan path. It counts scan lines on a line-tick strobe from the horizontal counter. It derives vertical sync, blank and active-video flags, the active line number, a start-of-frame pulse and a frame counter for the pixel pipeline. Porch, sync and active lengths and the sync polarity are parameters, and every output is registered and aligned with the line count.

## Interface

- V_ACTIVE, 480, active (visible) lines per frame
- V_FP, 10, front-porch lines
- V_SYNC, 2, sync-pulse lines
- V_BP, 33, back-porch lines
- SYNC_POL, 0, asserted level of vsync (0 = active-low)
- CNT_W, 10, width of cntrv and vline; must satisfy 2^CNT_W >= V_TOTAL
- FCNT_W, 8, width of frame_cnt

- clkv  input  1  line-domain clock
- clrv  input  1  reset; synchronous, active-high
- line_tick  input  1  one-cycle end-of-line strobe; advances the count
- cntrv  output  CNT_W  current line, 0..V_TOTAL-1
- vline  output  CNT_W  active line number; holds last value outside active region
- vactive  output  1  high while cntrv < V_ACTIVE
- vblank  output  1  inverse of vactive
- vsync  output  1  driven to SYNC_POL during the sync region, else ~SYNC_POL
- frame_start  output  1  one-cycle pulse when cntrv wraps to 0
- frame_cnt  output  FCNT_W  completed-frame count, wraps modulo 2^FCNT_W

## Operation

- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Regions, in order:
  - active: cntrv 0..V_ACTIVE-1
  - front porch: V_ACTIVE..V_ACTIVE+V_FP-1
  - sync: V_ACTIVE+V_FP..V_ACTIVE+V_FP+V_SYNC-1 (default 490..491)
  - back porch: through V_TOTAL-1
- Counter behaviour:
  - line_tick=1 and cntrv==V_TOTAL-1: cntrv -> 0.
  - line_tick=1 otherwise: cntrv -> cntrv+1.
  - line_tick=0: all outputs hold, and frame_start -> 0.
- Flags are decoded from the next count value and registered, so they change on the same edge as cntrv. There is no skew between cntrv and the flags.
- vline = cntrv while active. It freezes at V_ACTIVE-1 during blanking and returns to 0 with the wrap.
- On wrap:
  - frame_start=1 for exactly one clkv cycle.
  - frame_cnt increments, and rolls from 2^FCNT_W-1 to 0.
- Reset values:
  - cntrv=0, vline=0, vactive=1, vblank=0.
  - vsync=~SYNC_POL (inactive).
  - frame_start=0, frame_cnt=0.
- Reset does not generate frame_start.
- Degenerate parameters:
  - V_FP=0 or V_BP=0 is legal; sync then borders active or the wrap.
  - V_SYNC>=1 and V_ACTIVE>=1 are required.

## Timing

- Latency: one clkv edge from a sampled line_tick to the updated cntrv and all flags.
- clrv has priority over line_tick in the same cycle. Result is the reset values, with no count and no frame_start.
- clrv asserted mid-frame (e.g. at line 300) returns to line 0 on the next edge.
- After clrv deasserts, counting resumes from 0 on the next line_tick.
- line_tick held high continuously: the count advances every clkv cycle. A full frame takes V_TOTAL cycles, and frame_start pulses every V_TOTAL cycles.
- Back-to-back frames have no gap cycle: V_TOTAL-1 -> 0 -> 1 on consecutive ticks.
- vsync asserts on the edge where cntrv becomes V_ACTIVE+V_FP. It deasserts on the edge where cntrv becomes V_ACTIVE+V_FP+V_SYNC.

## Test plan

- Reset, then line_tick held 1 for 525 cycles (defaults):
  - cntrv wraps 524 -> 0.
  - vactive high for cntrv 0..479.
  - vsync low exactly at cntrv 490..491.
  - frame_start single pulse at the wrap; frame_cnt=1.
- line_tick pulsed every 4th cycle:
  - outputs change only on tick edges.
  - vline stays at 479 during cntrv 480..524, then goes to 0 at the wrap.
- clrv asserted at cntrv=300 with line_tick=1 in the same cycle:
  - next edge gives cntrv=0, vactive=1, frame_start=0.
  - frame_cnt reset to 0.
- SYNC_POL=1, V_ACTIVE=4, V_FP=0, V_SYNC=1, V_BP=1:
  - cntrv sequence 0,1,2,3,4,5,0.
  - vsync=1 only at cntrv=4.
  - frame_start pulses on every 6th tick.
- FCNT_W=2, 5 full frames: frame_cnt sequence 1,2,3,0,1.
- Reset release with line_tick=0 for 10 cycles: all outputs hold their reset values, and there is no frame_start.

Source files
------------

// File: rtl/vtiming_gen.sv
// Vertical timing generator: counts scan lines on line_tick and produces
// registered sync/blank/active flags, active line number and frame counters.
module vtiming_gen #(
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10,
  parameter int FCNT_W   = 8
) (
  input  logic              clkv,
  input  logic              clrv,
  input  logic              line_tick,
  output logic [CNT_W-1:0]  cntrv,
  output logic [CNT_W-1:0]  vline,
  output logic              vactive,
  output logic              vblank,
  output logic              vsync,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Region bounds carry one extra bit so a sync region ending exactly at
  // 2^CNT_W does not alias to zero.
  localparam logic [CNT_W:0]   ACT_END  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   SYNC_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   SYNC_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic             VS_ON    = (SYNC_POL != 0);

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_vline;
  logic              r_vactive;
  logic              r_vblank;
  logic              r_vsync;
  logic              r_fstart;
  logic [FCNT_W-1:0] r_fcnt;

  logic              w_wrap;
  logic [CNT_W-1:0]  w_nxt;
  logic [CNT_W:0]    w_nxt_x;
  logic              w_act;
  logic              w_sync;

  // Flags are decoded from the next count so they land on the same edge.
  always_comb begin
    w_wrap  = (r_cnt == LAST);
    w_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_nxt_x = {1'b0, w_nxt};
    w_act   = (w_nxt_x < ACT_END);
    w_sync  = (w_nxt_x >= SYNC_BEG) && (w_nxt_x < SYNC_END);
  end

  always_ff @(posedge clkv) begin
    if (clrv) begin
      r_cnt     <= '0;
      r_vline   <= '0;
      r_vactive <= 1'b1;
      r_vblank  <= 1'b0;
      r_vsync   <= ~VS_ON;
      r_fstart  <= 1'b0;
      r_fcnt    <= '0;
    end else if (line_tick) begin
      r_cnt     <= w_nxt;
      if (w_act)
        r_vline <= w_nxt;
      r_vactive <= w_act;
      r_vblank  <= ~w_act;
      r_vsync   <= w_sync ? VS_ON : ~VS_ON;
      r_fstart  <= w_wrap;
      if (w_wrap)
        r_fcnt  <= r_fcnt + FCNT_W'(1);
    end else begin
      r_fstart  <= 1'b0;
    end
  end

  assign cntrv       = r_cnt;
  assign vline       = r_vline;
  assign vactive     = r_vactive;
  assign vblank      = r_vblank;
  assign vsync       = r_vsync;
  assign frame_start = r_fstart;
  assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_vtiming_gen.sv
// Directed bench for vtiming_gen: default 525-line timing plus a tiny
// 6-line, positive-sync, 2-bit frame counter configuration.
module tb_vtiming_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration
  logic       clr0, tick0;
  logic [9:0] cnt0, vline0;
  logic       vact0, vblk0, vs0, fs0;
  logic [7:0] fcnt0;

  vtiming_gen dut0 (
    .clkv(clk), .clrv(clr0), .line_tick(tick0),
    .cntrv(cnt0), .vline(vline0), .vactive(vact0), .vblank(vblk0),
    .vsync(vs0), .frame_start(fs0), .frame_cnt(fcnt0)
  );

  // Small configuration
  logic       clr1, tick1;
  logic [3:0] cnt1, vline1;
  logic       vact1, vblk1, vs1, fs1;
  logic [1:0] fcnt1;

  vtiming_gen #(
    .V_ACTIVE(4), .V_FP(0), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .CNT_W(4), .FCNT_W(2)
  ) dut1 (
    .clkv(clk), .clrv(clr1), .line_tick(tick1),
    .cntrv(cnt1), .vline(vline1), .vactive(vact1), .vblank(vblk1),
    .vsync(vs1), .frame_start(fs1), .frame_cnt(fcnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, ".cntrv"},   32'(cnt0),   0);
    chk({tag, ".vline"},   32'(vline0), 0);
    chk({tag, ".vactive"}, 32'(vact0),  1);
    chk({tag, ".vblank"},  32'(vblk0),  0);
    chk({tag, ".vsync"},   32'(vs0),    1);
    chk({tag, ".fstart"},  32'(fs0),    0);
    chk({tag, ".fcnt"},    32'(fcnt0),  0);
  endtask

  initial begin
    int e;
    clr0 = 1'b1; tick0 = 1'b0;
    clr1 = 1'b1; tick1 = 1'b0;
    step(2);
    clr0 = 1'b0;
    chk_reset0("rst");

    // Idle after reset: everything holds, no frame_start
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle.fstart", 32'(fs0), 0);
    end
    chk_reset0("idle");

    // Continuous ticks: one full frame
    tick0 = 1'b1;
    for (int i = 1; i <= 525; i++) begin
      step(1);
      e = i % 525;
      chk("run.cntrv",   32'(cnt0),   32'(e));
      chk("run.vactive", 32'(vact0),  32'(e < 480));
      chk("run.vblank",  32'(vblk0),  32'(e >= 480));
      chk("run.vsync",   32'(vs0),    32'(!(e == 490 || e == 491)));
      chk("run.fstart",  32'(fs0),    32'(e == 0));
      chk("run.vline",   32'(vline0), 32'((e < 480) ? e : 479));
    end
    chk("run.fcnt", 32'(fcnt0), 1);

    // Tick every 4th cycle: outputs move only on tick edges
    tick0 = 1'b0;
    for (int p = 1; p <= 525; p++) begin
      tick0 = 1'b1;
      step(1);
      tick0 = 1'b0;
      e = p % 525;
      chk("sparse.cntrv",  32'(cnt0),   32'(e));
      chk("sparse.vline",  32'(vline0), 32'((e < 480) ? e : 479));
      chk("sparse.fstart", 32'(fs0),    32'(e == 0));
      step(3);
      chk("hold.cntrv",  32'(cnt0),   32'(e));
      chk("hold.vline",  32'(vline0), 32'((e < 480) ? e : 479));
      chk("hold.fstart", 32'(fs0),    0);
    end
    chk("sparse.fcnt", 32'(fcnt0), 2);

    // Mid-frame reset coinciding with a tick
    tick0 = 1'b1;
    step(300);
    chk("pre_clr.cntrv", 32'(cnt0), 300);
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    chk_reset0("midclr");
    step(1);
    chk("resume.cntrv", 32'(cnt0), 1);
    chk("resume.vline", 32'(vline0), 1);
    tick0 = 1'b0;

    // Small configuration: 6 lines/frame, sync at line 4, 2-bit frame count
    step(1);
    clr1 = 1'b0;
    chk("s.rst.cntrv", 32'(cnt1), 0);
    chk("s.rst.vsync", 32'(vs1),  0);
    chk("s.rst.fcnt",  32'(fcnt1), 0);
    tick1 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      e = i % 6;
      chk("s.cntrv",   32'(cnt1),   32'(e));
      chk("s.vsync",   32'(vs1),    32'(e == 4));
      chk("s.vactive", 32'(vact1),  32'(e < 4));
      chk("s.vblank",  32'(vblk1),  32'(e >= 4));
      chk("s.vline",   32'(vline1), 32'((e < 4) ? e : 3));
      chk("s.fstart",  32'(fs1),    32'(e == 0));
      chk("s.fcnt",    32'(fcnt1),  32'((i / 6) % 4));
    end
    chk("s.fcnt_end", 32'(fcnt1), 1);
    tick1 = 1'b0;
    step(1);
    chk("s.fstart_drop", 32'(fs1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
